// File: rtl/ctrl_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit: opcodes, step
// states, instruction classes, bus-select and ALU function codes.
package ctrl_pkg;

  // Opcodes (IR[31:27])
  localparam logic [4:0] OpRol  = 5'b01000;
  localparam logic [4:0] OpAddi = 5'b01001;
  localparam logic [4:0] OpAndi = 5'b01010;
  localparam logic [4:0] OpOri  = 5'b01011;
  localparam logic [4:0] OpDiv  = 5'b01100;
  localparam logic [4:0] OpMul  = 5'b01101;
  localparam logic [4:0] OpNeg  = 5'b01110;
  localparam logic [4:0] OpNot  = 5'b01111;
  localparam logic [4:0] OpLd   = 5'b10000;
  localparam logic [4:0] OpLdi  = 5'b10001;
  localparam logic [4:0] OpSt   = 5'b10010;
  localparam logic [4:0] OpJr   = 5'b10100;
  localparam logic [4:0] OpBrx  = 5'b10101;
  localparam logic [4:0] OpIn   = 5'b10110;
  localparam logic [4:0] OpOut  = 5'b10111;
  localparam logic [4:0] OpMfhi = 5'b11000;
  localparam logic [4:0] OpMflo = 5'b11001;
  localparam logic [4:0] OpHalt = 5'b11011;

  // Bus source codes (0-15 are the GPRs themselves)
  localparam logic [4:0] SelHi     = 5'd16;
  localparam logic [4:0] SelLo     = 5'd17;
  localparam logic [4:0] SelZhi    = 5'd18;
  localparam logic [4:0] SelZlo    = 5'd19;
  localparam logic [4:0] SelPc     = 5'd20;
  localparam logic [4:0] SelMdr    = 5'd21;
  localparam logic [4:0] SelInPort = 5'd22;

  // ALU functions used by non-ALU instructions
  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;

  typedef enum logic [3:0] {
    StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClsAlu, ClsImm, ClsMulDiv, ClsUnary, ClsLd, ClsLdi, ClsSt, ClsJr,
    ClsBrx, ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsHalt, ClsNone
  } cls_e;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode to instruction-class decode, plus the ALU function each class uses.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] opc_i,
  output cls_e       cls_o,
  output logic [3:0] alu_op_o
);

  // Classify the opcode; nop, jal and undefined opcodes fall into ClsNone
  always_comb begin
    cls_o    = ClsNone;
    alu_op_o = opc_i[3:0];
    case (opc_i)
      OpAddi: begin cls_o = ClsImm; alu_op_o = AluAdd; end
      OpAndi: begin cls_o = ClsImm; alu_op_o = AluAnd; end
      OpOri:  begin cls_o = ClsImm; alu_op_o = AluOr;  end
      OpDiv, OpMul: cls_o = ClsMulDiv;
      OpNeg, OpNot: cls_o = ClsUnary;
      OpLd:   begin cls_o = ClsLd;  alu_op_o = AluAdd; end
      OpLdi:  begin cls_o = ClsLdi; alu_op_o = AluAdd; end
      OpSt:   begin cls_o = ClsSt;  alu_op_o = AluAdd; end
      OpJr:   cls_o = ClsJr;
      OpBrx:  begin cls_o = ClsBrx; alu_op_o = AluAdd; end
      OpIn:   cls_o = ClsIn;
      OpOut:  cls_o = ClsOut;
      OpMfhi: cls_o = ClsMfhi;
      OpMflo: cls_o = ClsMflo;
      OpHalt: cls_o = ClsHalt;
      default: if (opc_i <= OpRol) cls_o = ClsAlu;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: step-state sequencer with Moore decode of
// every datapath control from the registered step and the IR.
// Optional build macro CTRL_MEM_WAIT_EN adds mem_ready; memory steps then hold
// until mem_ready is high at a clock edge.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 5
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] IR,
  input  logic              CON_out,
`ifdef CTRL_MEM_WAIT_EN
  input  logic              mem_ready,
`endif
  output logic              e_PC,
  output logic              incPC,
  output logic              e_IR,
  output logic              e_Y,
  output logic              e_Z,
  output logic              e_HI,
  output logic              e_LO,
  output logic              e_MAR,
  output logic              e_MDR,
  output logic              MDR_read,
  output logic              ram_read,
  output logic              ram_write,
  output logic              RA_en,
  output logic              CON_enable,
  output logic              e_OutPort,
  output logic              e_InPort,
  output logic              Gra,
  output logic              Grb,
  output logic              Grc,
  output logic              e_Rin,
  output logic              e_Rout,
  output logic              BAout,
  output logic              imm_sel,
  output logic [3:0]        ALU_op,
  output logic [SEL_W-1:0]  BusDataSelect,
  output logic              run
);

  state_e     state_q, state_d;
  cls_e       cls;
  logic [3:0] alu_dec;
  logic [4:0] sel;
  logic [4:0] sel_ra, sel_rb, sel_rc;
  logic       mem_hold;
  logic       unused_ir;

  assign sel_ra        = {1'b0, IR[26:23]};
  assign sel_rb        = {1'b0, IR[22:19]};
  assign sel_rc        = {1'b0, IR[18:15]};
  assign unused_ir     = ^IR[14:0];
  assign BusDataSelect = SEL_W'(sel);

`ifdef CTRL_MEM_WAIT_EN
  assign mem_hold = (ram_read | ram_write) & ~mem_ready;
`else
  assign mem_hold = 1'b0;
`endif

  ctrl_decode u_decode (
    .opc_i    (IR[31:27]),
    .cls_o    (cls),
    .alu_op_o (alu_dec)
  );

  // Next step; class is only consulted from T3, once the new IR is in place
  always_comb begin
    state_d = StT0;
    case (state_q)
      StT0: state_d = StT1;
      StT1: state_d = StT2;
      StT2: state_d = StT3;
      StT3: begin
        case (cls)
          ClsHalt: state_d = StHalt;
          ClsJr, ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsNone: state_d = StT0;
          default: state_d = StT4;
        endcase
      end
      StT4:    state_d = (cls == ClsUnary) ? StT0 : StT5;
      StT5:    state_d = (cls inside {ClsAlu, ClsImm, ClsLdi}) ? StT0 : StT6;
      StT6:    state_d = (cls inside {ClsLd, ClsBrx}) ? StT7 : StT0;
      StT7:    state_d = StT0;
      StHalt:  state_d = StHalt;
      default: state_d = StT0;
    endcase
  end

  // Step register; a pending memory access freezes the current step
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= StT0;
    end else if (!mem_hold) begin
      state_q <= state_d;
    end
  end

  // Control decode from step and instruction class
  always_comb begin
    {e_PC, incPC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MAR, e_MDR, MDR_read} = '0;
    {ram_read, ram_write, RA_en, CON_enable, e_OutPort, e_InPort} = '0;
    {Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel} = '0;
    ALU_op = '0;
    sel    = '0;
    run    = (state_q != StHalt);
    case (state_q)
      StT0: begin sel = SelPc; e_MAR = 1'b1; incPC = 1'b1; end
      StT1: begin ram_read = 1'b1; MDR_read = 1'b1; e_MDR = 1'b1; end
      StT2: begin sel = SelMdr; e_IR = 1'b1; end
      StT3: begin
        case (cls)
          ClsAlu, ClsImm: begin sel = sel_rb; e_Rout = 1'b1; Grb = 1'b1; e_Y = 1'b1; end
          ClsMulDiv: begin sel = sel_ra; e_Rout = 1'b1; Gra = 1'b1; e_Y = 1'b1; end
          ClsUnary: begin
            sel = sel_rb; e_Rout = 1'b1; Grb = 1'b1; ALU_op = alu_dec; e_Z = 1'b1;
          end
          ClsLd, ClsLdi, ClsSt: begin
            sel = sel_rb; e_Rout = 1'b1; Grb = 1'b1; BAout = 1'b1; e_Y = 1'b1;
          end
          ClsJr:   begin sel = sel_ra; e_Rout = 1'b1; Gra = 1'b1; e_PC = 1'b1; end
          ClsBrx:  begin sel = sel_ra; e_Rout = 1'b1; Gra = 1'b1; RA_en = 1'b1; end
          ClsIn:   begin sel = SelInPort; e_Rin = 1'b1; Gra = 1'b1; end
          ClsOut:  begin sel = sel_ra; e_Rout = 1'b1; Gra = 1'b1; e_OutPort = 1'b1; end
          ClsMfhi: begin sel = SelHi; e_Rin = 1'b1; Gra = 1'b1; end
          ClsMflo: begin sel = SelLo; e_Rin = 1'b1; Gra = 1'b1; end
          default: ;
        endcase
      end
      StT4: begin
        case (cls)
          ClsAlu: begin
            sel = sel_rc; e_Rout = 1'b1; Grc = 1'b1; ALU_op = alu_dec; e_Z = 1'b1;
          end
          ClsMulDiv: begin
            sel = sel_rb; e_Rout = 1'b1; Grb = 1'b1; ALU_op = alu_dec; e_Z = 1'b1;
          end
          ClsImm, ClsLd, ClsLdi, ClsSt: begin imm_sel = 1'b1; ALU_op = alu_dec; e_Z = 1'b1; end
          ClsUnary: begin sel = SelZlo; e_Rin = 1'b1; Gra = 1'b1; end
          ClsBrx:   CON_enable = 1'b1;
          default: ;
        endcase
      end
      StT5: begin
        case (cls)
          ClsAlu, ClsImm, ClsLdi: begin sel = SelZlo; e_Rin = 1'b1; Gra = 1'b1; end
          ClsMulDiv:    begin sel = SelZlo; e_LO = 1'b1; end
          ClsLd, ClsSt: begin sel = SelZlo; e_MAR = 1'b1; end
          ClsBrx:       begin sel = SelPc; e_Y = 1'b1; end
          default: ;
        endcase
      end
      StT6: begin
        case (cls)
          ClsMulDiv: begin sel = SelZhi; e_HI = 1'b1; end
          ClsLd:     begin ram_read = 1'b1; MDR_read = 1'b1; e_MDR = 1'b1; end
          ClsSt:     begin sel = sel_ra; e_Rout = 1'b1; Gra = 1'b1; ram_write = 1'b1; end
          ClsBrx:    begin imm_sel = 1'b1; ALU_op = AluAdd; e_Z = 1'b1; end
          default: ;
        endcase
      end
      StT7: begin
        if (cls == ClsLd) begin
          sel = SelMdr; e_Rin = 1'b1; Gra = 1'b1;
        end else if (cls == ClsBrx && CON_out) begin
          sel = SelZlo; e_PC = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-opcode step tables built from
// the instruction set rules, compared against the DUT every cycle.
module tb_control_sequencer;

  typedef struct packed {
    logic e_PC, incPC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MAR, e_MDR, MDR_read;
    logic ram_read, ram_write, RA_en, CON_enable, e_OutPort, e_InPort;
    logic Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel;
    logic [3:0] alu;
    logic [4:0] sel;
    logic run;
  } outs_t;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] IR = '0;
  logic        CON_out = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
  logic        mem_ready = 1'b1;
`endif
  logic e_PC, incPC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MAR, e_MDR, MDR_read;
  logic ram_read, ram_write, RA_en, CON_enable, e_OutPort, e_InPort;
  logic Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, run;
  logic [3:0] ALU_op;
  logic [4:0] BusDataSelect;

  control_sequencer #(.DATA_W(32), .SEL_W(5)) dut (
    .clock(clock), .clear(clear), .IR(IR), .CON_out(CON_out),
`ifdef CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .e_PC(e_PC), .incPC(incPC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI),
    .e_LO(e_LO), .e_MAR(e_MAR), .e_MDR(e_MDR), .MDR_read(MDR_read),
    .ram_read(ram_read), .ram_write(ram_write), .RA_en(RA_en), .CON_enable(CON_enable),
    .e_OutPort(e_OutPort), .e_InPort(e_InPort), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .e_Rin(e_Rin), .e_Rout(e_Rout), .BAout(BAout), .imm_sel(imm_sel),
    .ALU_op(ALU_op), .BusDataSelect(BusDataSelect), .run(run)
  );

  outs_t dut_o;
  assign dut_o = {e_PC, incPC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MAR, e_MDR, MDR_read,
                  ram_read, ram_write, RA_en, CON_enable, e_OutPort, e_InPort,
                  Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, ALU_op, BusDataSelect, run};

  int    n_checks = 0;
  int    n_pass = 0;
  bit    chk_en = 1'b0;
  outs_t exp_cur;
  string tag = "reset";
  outs_t steps[$];

  always #5 clock = ~clock;

  // Cycle compare against the model's current expected step
  always @(negedge clock) begin
    if (chk_en) begin
      n_checks++;
      if (dut_o === exp_cur) n_pass++;
      else $display("FAIL %s: outputs %h, required %h", tag, dut_o, exp_cur);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic outs_t idle();
    outs_t o = '0;
    o.run = 1'b1;
    return o;
  endfunction

  // Register onto the bus; g: 0=Ra, 1=Rb, 2=Rc
  function automatic outs_t rout(input logic [3:0] r, input int g);
    outs_t o = idle();
    o.sel = {1'b0, r};
    o.e_Rout = 1'b1;
    if (g == 0) o.Gra = 1'b1;
    else if (g == 1) o.Grb = 1'b1;
    else o.Grc = 1'b1;
    return o;
  endfunction

  // Bus source into Ra
  function automatic outs_t rin(input logic [4:0] src);
    outs_t o = idle();
    o.sel = src;
    o.e_Rin = 1'b1;
    o.Gra = 1'b1;
    return o;
  endfunction

  // Expected step list for one instruction, straight from the opcode table
  function automatic void build(input logic [31:0] ir, input logic con, output bit halts);
    logic [4:0] opc = ir[31:27];
    logic [3:0] ra = ir[26:23];
    logic [3:0] rb = ir[22:19];
    logic [3:0] rc = ir[18:15];
    outs_t o;
    steps.delete();
    halts = 1'b0;
    o = idle(); o.sel = 20; o.e_MAR = 1; o.incPC = 1; steps.push_back(o);
    o = idle(); o.ram_read = 1; o.MDR_read = 1; o.e_MDR = 1; steps.push_back(o);
    o = idle(); o.sel = 21; o.e_IR = 1; steps.push_back(o);
    if (opc <= 5'd11) begin
      o = rout(rb, 1); o.e_Y = 1; steps.push_back(o);
      if (opc <= 5'd8) begin
        o = rout(rc, 2); o.alu = opc[3:0];
      end else begin
        o = idle(); o.imm_sel = 1;
        o.alu = (opc == 5'd9) ? 4'd0 : (opc == 5'd10) ? 4'd2 : 4'd3;
      end
      o.e_Z = 1; steps.push_back(o);
      steps.push_back(rin(19));
    end else if (opc == 5'd12 || opc == 5'd13) begin
      o = rout(ra, 0); o.e_Y = 1; steps.push_back(o);
      o = rout(rb, 1); o.alu = opc[3:0]; o.e_Z = 1; steps.push_back(o);
      o = idle(); o.sel = 19; o.e_LO = 1; steps.push_back(o);
      o = idle(); o.sel = 18; o.e_HI = 1; steps.push_back(o);
    end else if (opc == 5'd14 || opc == 5'd15) begin
      o = rout(rb, 1); o.alu = opc[3:0]; o.e_Z = 1; steps.push_back(o);
      steps.push_back(rin(19));
    end else if (opc >= 5'd16 && opc <= 5'd18) begin
      o = rout(rb, 1); o.BAout = 1; o.e_Y = 1; steps.push_back(o);
      o = idle(); o.imm_sel = 1; o.e_Z = 1; steps.push_back(o);
      if (opc == 5'd17) begin
        steps.push_back(rin(19));
      end else begin
        o = idle(); o.sel = 19; o.e_MAR = 1; steps.push_back(o);
        if (opc == 5'd16) begin
          o = idle(); o.ram_read = 1; o.MDR_read = 1; o.e_MDR = 1; steps.push_back(o);
          steps.push_back(rin(21));
        end else begin
          o = rout(ra, 0); o.ram_write = 1; steps.push_back(o);
        end
      end
    end else begin
      case (opc)
        5'd20: begin o = rout(ra, 0); o.e_PC = 1; steps.push_back(o); end
        5'd21: begin
          o = rout(ra, 0); o.RA_en = 1; steps.push_back(o);
          o = idle(); o.CON_enable = 1; steps.push_back(o);
          o = idle(); o.sel = 20; o.e_Y = 1; steps.push_back(o);
          o = idle(); o.imm_sel = 1; o.e_Z = 1; steps.push_back(o);
          o = idle();
          if (con) begin o.sel = 19; o.e_PC = 1; end
          steps.push_back(o);
        end
        5'd22: steps.push_back(rin(22));
        5'd23: begin o = rout(ra, 0); o.e_OutPort = 1; steps.push_back(o); end
        5'd24: steps.push_back(rin(16));
        5'd25: steps.push_back(rin(17));
        5'd27: begin steps.push_back(idle()); halts = 1'b1; end
        default: steps.push_back(idle());
      endcase
    end
  endfunction

  // Play one instruction; IR is loaded as the datapath would at the end of T2
  task automatic run_instr(input logic [31:0] ir, input logic con, input int wait_cyc,
                           input int abort_at, input int halt_cycles, input string name);
    bit halts;
    outs_t h;
    build(ir, con, halts);
    CON_out = con;
    IR = $urandom;
    foreach (steps[i]) begin
      exp_cur = steps[i];
      tag = $sformatf("%s T%0d", name, i);
      if (i == abort_at) begin
        @(negedge clock);
        #1 clear = 1'b0;
        exp_cur = steps[0];
        tag = $sformatf("%s abort", name);
        #1 chk({name, "_abort_sel"}, 32'(BusDataSelect), 32'd20);
        @(posedge clock);
        #1 clear = 1'b1;
        return;
      end
`ifdef CTRL_MEM_WAIT_EN
      if (steps[i].ram_read || steps[i].ram_write) begin
        mem_ready = 1'b0;
        repeat (wait_cyc) begin @(posedge clock); #1; end
        mem_ready = 1'b1;
      end
`endif
      @(posedge clock);
      #1;
      if (i == 2) IR = ir;
    end
    if (halts) begin
      h = '0;
      exp_cur = h;
      tag = $sformatf("%s halted", name);
      repeat (halt_cycles) begin @(posedge clock); #1; end
      chk({name, "_halt_run"}, 32'(run), 32'd0);
      clear = 1'b0;
      exp_cur = steps[0];
      tag = $sformatf("%s restart", name);
      #1 chk({name, "_restart_sel"}, 32'(BusDataSelect), 32'd20);
      @(posedge clock);
      #1 clear = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] ir;
    exp_cur = idle();
    exp_cur.sel = 20; exp_cur.e_MAR = 1; exp_cur.incPC = 1;
    #1 clear = 1'b0;
    #1;
    chk("reset_sel", 32'(BusDataSelect), 32'd20);
    chk("reset_e_MAR", 32'(e_MAR), 32'd1);
    chk("reset_incPC", 32'(incPC), 32'd1);
    chk("reset_run", 32'(run), 32'd1);
    chk_en = 1'b1;
    repeat (2) @(posedge clock);
    #1 clear = 1'b1;

    // add R1,R2,R3
    run_instr({5'b00000, 4'd1, 4'd2, 4'd3, 15'd0}, 1'b0, 0, -1, 0, "add");
    chk("add_len", 32'(steps.size()), 32'd6);
    chk("add_T3_sel", 32'(steps[3].sel), 32'd2);
    chk("add_T4_sel", 32'(steps[4].sel), 32'd3);
    chk("add_T4_eZ", 32'(steps[4].e_Z), 32'd1);
    chk("add_T5_sel", 32'(steps[5].sel), 32'd19);

    // Same add, reset during T5
    run_instr({5'b00000, 4'd1, 4'd2, 4'd3, 15'd0}, 1'b0, 0, 5, 0, "add_abort");

    // ld R4,0x10(R0)
    run_instr({5'b10000, 4'd4, 4'd0, 19'h10}, 1'b0, 0, -1, 0, "ld");
    chk("ld_T3_BAout", 32'(steps[3].BAout), 32'd1);
    chk("ld_T4_imm", 32'(steps[4].imm_sel), 32'd1);
    chk("ld_T6_read", 32'(steps[6].ram_read), 32'd1);
    chk("ld_T7_sel", 32'(steps[7].sel), 32'd21);

    // brx not taken, then taken
    run_instr({5'b10101, 4'd6, 4'd0, 19'd8}, 1'b0, 0, -1, 0, "brx_nt");
    chk("brx_nt_T7_ePC", 32'(steps[7].e_PC), 32'd0);
    run_instr({5'b10101, 4'd6, 4'd0, 19'd8}, 1'b1, 0, -1, 0, "brx_t");
    chk("brx_t_T7_ePC", 32'(steps[7].e_PC), 32'd1);

    // halt, idle 20 cycles, clear restarts
    run_instr({5'b11011, 27'd0}, 1'b0, 0, -1, 20, "halt");

`ifdef CTRL_MEM_WAIT_EN
    run_instr({5'b10000, 4'd4, 4'd0, 19'h10}, 1'b0, 3, -1, 0, "ld_wait");
`endif

    for (int n = 0; n < 300; n++) begin
      r  = $urandom;
      ir = {5'($urandom_range(0, 31)), r[26:0]};
      run_instr(ir, 1'($urandom_range(0, 1)), $urandom_range(0, 3), -1, 5,
                $sformatf("rnd%0d op%0d", n, ir[31:27]));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Mini SRC control unit, directly upstream of the datapath.
- Sequences fetch/decode/execute one instruction at a time.
- Drives every datapath enable, bus-select, ALU-op and memory strobe from a registered step state plus the instruction register contents.

Parameters:
DATA_W, 32, instruction/data width
SEL_W, 5, bus select width

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous, active-low reset
IR  in  32  instruction register contents (opc=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15])
CON_out  in  1  branch condition flip-flop
e_PC, incPC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MAR, e_MDR, MDR_read  out  1 each  datapath register controls
ram_read, ram_write, RA_en, CON_enable, e_OutPort, e_InPort  out  1 each  memory/condition/IO strobes
Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel  out  1 each  register-select and operand controls
ALU_op  out  4  ALU function
BusDataSelect  out  SEL_W  bus source: 0-15 GPR, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort
run  out  1  low only in HALT

Behaviour:
- Moore style: outputs decode combinationally from registered state and IR. All unlisted outputs are 0 in every step. Datapath captures at the rising edge ending each step.
- Reset (clear low, asynchronous): state=T0, all outputs 0 except the T0 decode, run=1. Reset mid-instruction abandons it; the next fetch starts at T0 once clear releases.
- States: T0..T7, HALT. Fetch is common to all instructions:
  - T0: Sel=PC, e_MAR, incPC.
  - T1: ram_read, MDR_read, e_MDR.
  - T2: Sel=MDR, e_IR.
- Register-out steps:
  - BusDataSelect = selected field; e_Rout=1; Gra/Grb/Grc marks the field.
  - BAout accompanies Rb in address calculations (R0 reads as 0).
- Register-in steps: e_Rin=1 with Gra.
- Execute, per opcode; the last listed step returns to T0:
  - add..rol (00000-01000): T3 Rb->Y; T4 Rc on bus, ALU_op=opc[3:0], e_Z; T5 Zlow->Ra. 6 cycles total.
  - addi/andi/ori (01001-01011): T3 Rb->Y; T4 imm_sel, ALU_op=0000/0010/0011, e_Z; T5 Zlow->Ra.
  - div/mul (01100/01101): T3 Ra->Y; T4 Rb on bus, ALU_op=opc[3:0], e_Z; T5 Zlow->LO; T6 Zhigh->HI.
  - neg/not (01110/01111): T3 Rb on bus, ALU_op, e_Z; T4 Zlow->Ra.
  - ld/ldi/st (10000/10001/10010): T3 Rb(BAout)->Y; T4 imm_sel, ALU_op=0000, e_Z; T5 Zlow->MAR (ldi: Zlow->Ra, done).
    - ld: T6 ram_read, MDR_read, e_MDR; T7 MDR->Ra.
    - st: T6 Ra on bus, ram_write.
  - jr (10100): T3 Ra->PC.
  - brx (10101): T3 Ra on bus, RA_en; T4 CON_enable; T5 PC->Y; T6 imm_sel, add, e_Z; T7 Zlow->PC only if CON_out=1, else no-op.
  - in (10110): T3 InPort->Ra. out (10111): T3 Ra on bus, e_OutPort.
  - mfhi/mflo (11000/11001): T3 HI/LO->Ra.
  - nop (11010), jal (10011), undefined opcodes: T2 goes directly to T0.
  - halt (11011): T2->HALT. Remains there with all enables 0 and run=0 until reset.
- IR is stable from T3 onward. Decode uses IR only in T3+ (T2 sees the old IR and must not branch on it); the T2->T0/HALT decision uses the IR captured at the end of T2, so evaluate it in T3. Therefore nop and halt take T3 as an idle step.

Optional Feature:
- Macro CTRL_MEM_WAIT_EN.
- With the macro: extra input mem_ready (1 bit). Any step asserting ram_read or ram_write holds state and outputs until mem_ready=1 at a clock edge.
- Without the macro: memory steps are single-cycle, no mem_ready port.

Decomposition:
- Package ctrl_pkg: opcode constants, state enum, BusDataSelect codes, ALU_op codes.
- One sub-module, ctrl_decode: combinational opcode -> instruction-class decode.

Test Plan:
- Reset held low during T5 of add, then released -> state T0 next cycle; outputs Sel=20, e_MAR=1, incPC=1; run=1.
- IR=add R1,R2,R3 -> T3 Sel=2 e_Y; T4 Sel=3 ALU_op=0000 e_Z; T5 Sel=19 e_Rin Gra; T0 next.
- ld R4,0x10(R0) -> T3 BAout Grb; T4 imm_sel; T5 Sel=19 e_MAR; T6 ram_read; T7 Sel=21 e_Rin.
- brx with CON_out=0, then repeated with CON_out=1 -> e_PC asserted in T7 only on the taken pass.
- halt -> run=0 from the step after T3 onward; no enables for 20 cycles; clear pulse restarts fetch.
- CTRL_MEM_WAIT_EN with mem_ready low for 3 cycles in T1 -> T1 outputs held 4 cycles, then T2.
